mul_div_unit: RTL and testbench

//  Iterative RV32M multiply/divide unit in the EX stage, fed directly by the ID/EX pipeline register outputs
//  (DATA1, DATA2, ALU_OP). Runs MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU over multiple cycles and drives

---
 rtl/mul_div_unit_pkg.sv | 49 ++++
 rtl/mul_div_step.sv | 32 +++
 rtl/mul_div_unit.sv | 157 +++++++++++++++
 tb/tb_mul_div_unit.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mul_div_unit_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit.
package mul_div_unit_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned CNT_W = 6;
    localparam int unsigned ACC_W = 2 * XLEN;
    localparam int unsigned OP_W  = 5;

    // ALU_OP codes shared with the control unit and the ALU
    localparam logic [OP_W-1:0] ALU_MUL    = 5'b01000;
    localparam logic [OP_W-1:0] ALU_MULH   = 5'b01001;
    localparam logic [OP_W-1:0] ALU_MULHSU = 5'b01010;
    localparam logic [OP_W-1:0] ALU_MULHU  = 5'b01011;
    localparam logic [OP_W-1:0] ALU_DIV    = 5'b01100;
    localparam logic [OP_W-1:0] ALU_DIVU   = 5'b01101;
    localparam logic [OP_W-1:0] ALU_REM    = 5'b01110;
    localparam logic [OP_W-1:0] ALU_REMU   = 5'b01111;

    // Low three bits of an M-op code
    typedef enum logic [2:0] {
        MOP_MUL    = 3'b000,
        MOP_MULH   = 3'b001,
        MOP_MULHSU = 3'b010,
        MOP_MULHU  = 3'b011,
        MOP_DIV    = 3'b100,
        MOP_DIVU   = 3'b101,
        MOP_REM    = 3'b110,
        MOP_REMU   = 3'b111
    } mop_e;

    // Context captured at accept time and used for the final sign fixup
    typedef struct packed {
        mop_e op;
        logic neg;
    } op_ctx_t;

    function automatic logic is_mop(input logic [OP_W-1:0] op);
        return op[4:3] == 2'b01;
    endfunction

    function automatic logic [XLEN-1:0] cond_neg32(input logic n, input logic [XLEN-1:0] x);
        return n ? (~x + XLEN'(1)) : x;
    endfunction

    function automatic logic [ACC_W-1:0] cond_neg64(input logic n, input logic [ACC_W-1:0] x);
        return n ? (~x + ACC_W'(1)) : x;
    endfunction

endpackage

// File: rtl/mul_div_step.sv
// One radix-2 iteration: shift-add for multiply, shift-subtract-restore for divide.
module mul_div_step
    import mul_div_unit_pkg::*;
(
    input  logic             is_div,
    input  logic [ACC_W-1:0] acc_in,
    input  logic [XLEN-1:0]  opnd,
    output logic [ACC_W-1:0] acc_out
);

    logic [XLEN:0] sum;
    logic [XLEN:0] rem_sh;
    logic [XLEN:0] diff;

    // Multiply: acc = {hi, multiplier}; divide: acc = {remainder, dividend/quotient}
    always_comb begin
        acc_out = '0;
        sum     = {1'b0, acc_in[ACC_W-1:XLEN]} + (acc_in[0] ? {1'b0, opnd} : '0);
        rem_sh  = acc_in[ACC_W-1:XLEN-1];
        diff    = rem_sh - {1'b0, opnd};
        if (is_div) begin
            if (!diff[XLEN]) begin
                acc_out = {diff[XLEN-1:0], acc_in[XLEN-2:0], 1'b1};
            end else begin
                acc_out = {rem_sh[XLEN-1:0], acc_in[XLEN-2:0], 1'b0};
            end
        end else begin
            acc_out = {sum, acc_in[XLEN-1:1]};
        end
    end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative RV32M multiply/divide unit; stalls the pipeline via BUSY until RESULT is ready.
module mul_div_unit
    import mul_div_unit_pkg::*;
(
    input  logic            CLK,
    input  logic            RESET,
    input  logic            START,
    input  logic [OP_W-1:0] ALU_OP,
    input  logic [XLEN-1:0] DATA1,
    input  logic [XLEN-1:0] DATA2,
    input  logic            FLUSH,
    output logic [XLEN-1:0] RESULT,
    output logic            DONE,
    output logic            BUSY
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIN  = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [XLEN-1:0]  opnd_q, opnd_d;
    op_ctx_t          ctx_q, ctx_d;
    logic [XLEN-1:0]  result_d;
    logic             done_d;

    logic             accept;
    logic             in_div, a_signed, b_signed, a_neg, b_neg, in_neg;
    logic [XLEN-1:0]  mag1, mag2;
    logic             fast_hit;
    logic [XLEN-1:0]  fast_val;
    logic             run_div, run_rem;
    logic [ACC_W-1:0] step_acc, prod;
    logic [XLEN-1:0]  fix_val;

    // Operand decode, magnitudes and early-out cases for a newly presented op
    always_comb begin
        accept   = START && is_mop(ALU_OP) && !FLUSH;
        in_div   = ALU_OP[2];
        a_signed = in_div ? !ALU_OP[0] : (ALU_OP[1:0] != 2'b11);
        b_signed = in_div ? !ALU_OP[0] : !ALU_OP[1];
        a_neg    = a_signed && DATA1[XLEN-1];
        b_neg    = b_signed && DATA2[XLEN-1];
        mag1     = cond_neg32(a_neg, DATA1);
        mag2     = cond_neg32(b_neg, DATA2);
        in_neg   = (in_div && ALU_OP[1]) ? a_neg : (a_neg ^ b_neg);
        fast_hit = 1'b0;
        fast_val = '0;
        if (!in_div) begin
            fast_hit = (DATA1 == '0) || (DATA2 == '0);
        end else if (DATA2 == '0) begin
            fast_hit = 1'b1;
            fast_val = ALU_OP[1] ? DATA1 : '1;
        end else if (!ALU_OP[0] && (DATA1 == {1'b1, {(XLEN-1){1'b0}}}) && (DATA2 == '1)) begin
            fast_hit = 1'b1;
            fast_val = ALU_OP[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
        end
    end

    mul_div_step u_step (
        .is_div  (run_div),
        .acc_in  (acc_q),
        .opnd    (opnd_q),
        .acc_out (step_acc)
    );

    // Sign fixup and result selection on the final iteration
    always_comb begin
        run_div = ctx_q.op inside {MOP_DIV, MOP_DIVU, MOP_REM, MOP_REMU};
        run_rem = ctx_q.op inside {MOP_REM, MOP_REMU};
        prod    = cond_neg64(ctx_q.neg, step_acc);
        if (run_div) begin
            fix_val = cond_neg32(ctx_q.neg, run_rem ? step_acc[ACC_W-1:XLEN] : step_acc[XLEN-1:0]);
        end else begin
            fix_val = (ctx_q.op == MOP_MUL) ? prod[XLEN-1:0] : prod[ACC_W-1:XLEN];
        end
    end

    // Next-state, datapath updates and BUSY
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        opnd_d   = opnd_q;
        ctx_d    = ctx_q;
        result_d = RESULT;
        done_d   = 1'b0;
        BUSY     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    BUSY      = 1'b1;
                    ctx_d.op  = mop_e'(ALU_OP[2:0]);
                    ctx_d.neg = in_neg;
                    cnt_d     = '0;
                    if (fast_hit) begin
                        result_d = fast_val;
                        done_d   = 1'b1;
                        state_d  = ST_FIN;
                    end else begin
                        acc_d   = {{XLEN{1'b0}}, (in_div ? mag1 : mag2)};
                        opnd_d  = in_div ? mag2 : mag1;
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                BUSY  = 1'b1;
                acc_d = step_acc;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(XLEN-1)) begin
                    result_d = fix_val;
                    done_d   = 1'b1;
                    state_d  = ST_FIN;
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (FLUSH) begin
            state_d  = ST_IDLE;
            done_d   = 1'b0;
            result_d = RESULT;
            BUSY     = 1'b0;
        end
    end

    // State and datapath registers
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            opnd_q  <= '0;
            ctx_q   <= '0;
            RESULT  <= '0;
            DONE    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            opnd_q  <= opnd_d;
            ctx_q   <= ctx_d;
            RESULT  <= result_d;
            DONE    <= done_d;
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit: directed corner cases plus randomized ops.
module tb_mul_div_unit;

    localparam logic [4:0] T_MUL    = 5'b01000;
    localparam logic [4:0] T_MULH   = 5'b01001;
    localparam logic [4:0] T_MULHSU = 5'b01010;
    localparam logic [4:0] T_MULHU  = 5'b01011;
    localparam logic [4:0] T_DIV    = 5'b01100;
    localparam logic [4:0] T_DIVU   = 5'b01101;
    localparam logic [4:0] T_REM    = 5'b01110;
    localparam logic [4:0] T_REMU   = 5'b01111;

    logic        CLK = 1'b0;
    logic        RESET, START, FLUSH;
    logic [4:0]  ALU_OP;
    logic [31:0] DATA1, DATA2;
    logic [31:0] RESULT;
    logic        DONE, BUSY;

    logic [31:0] exp_q[$];
    logic [31:0] mon_exp;
    int drv_checks = 0, drv_errors = 0;
    int mon_checks = 0, mon_errors = 0;

    always #5 CLK = ~CLK;

    mul_div_unit dut (
        .CLK    (CLK),
        .RESET  (RESET),
        .START  (START),
        .ALU_OP (ALU_OP),
        .DATA1  (DATA1),
        .DATA2  (DATA2),
        .FLUSH  (FLUSH),
        .RESULT (RESULT),
        .DONE   (DONE),
        .BUSY   (BUSY)
    );

    // Reference: RV32M semantics with 64-bit integer arithmetic
    function automatic logic [31:0] model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        longint          sa, sb, ua, ub, p;
        longint unsigned pu;
        logic [63:0]     v;
        logic            ovf;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ua  = longint'({32'd0, a});
        ub  = longint'({32'd0, b});
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        v   = '0;
        case (op)
            T_MUL:    begin p = sa * sb; v = p; return v[31:0]; end
            T_MULH:   begin p = sa * sb; v = p; return v[63:32]; end
            T_MULHSU: begin p = sa * ub; v = p; return v[63:32]; end
            T_MULHU:  begin pu = longint'(ua) * longint'(ub); v = pu; return v[63:32]; end
            T_DIV: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ovf) return 32'h8000_0000;
                p = sa / sb; v = p; return v[31:0];
            end
            T_REM: begin
                if (b == 0) return a;
                if (ovf) return 32'h0;
                p = sa % sb; v = p; return v[31:0];
            end
            T_DIVU: begin
                if (b == 0) return 32'hFFFF_FFFF;
                return a / b;
            end
            T_REMU: begin
                if (b == 0) return a;
                return a % b;
            end
            default: return 32'h0;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        drv_checks++;
        if (act !== exp) begin
            drv_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        START = 1'b0;
        FLUSH = 1'b0;
        repeat (n) @(negedge CLK);
    endtask

    // Present an op, queue its expected result and wait for DONE (bounded)
    task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input int exp_lat, input string name);
        int   lat;
        logic busy_ok;
        ALU_OP = op;
        DATA1  = a;
        DATA2  = b;
        START  = 1'b1;
        FLUSH  = 1'b0;
        exp_q.push_back(exp);
        lat     = 0;
        busy_ok = 1'b1;
        do begin
            @(negedge CLK);
            lat++;
            if (BUSY !== !DONE) busy_ok = 1'b0;
        end while (DONE !== 1'b1 && lat < 60);
        if (DONE !== 1'b1) begin
            drv_errors++;
            $display("FAIL %s_timeout: got no DONE after %0d cycles, required DONE", name, lat);
        end
        if (exp_lat > 0) chk({name, "_latency"}, 32'(lat), 32'(exp_lat));
        chk({name, "_busy"}, {31'd0, busy_ok}, 32'd1);
    endtask

    // Monitor: every DONE pulse must match the oldest queued expectation
    always @(negedge CLK) begin
        if (RESET === 1'b1 && DONE === 1'b1) begin
            mon_checks++;
            if (exp_q.size() == 0) begin
                mon_errors++;
                $display("FAIL result: got unexpected DONE with RESULT %h, required no DONE", RESULT);
            end else begin
                mon_exp = exp_q.pop_front();
                if (RESULT !== mon_exp) begin
                    mon_errors++;
                    $display("FAIL result: got %h expected %h", RESULT, mon_exp);
                end
            end
        end
    end

    initial begin
        logic [4:0]  rop;
        logic [31:0] ra, rb;
        int          sel;

        RESET  = 1'b0;
        START  = 1'b0;
        FLUSH  = 1'b0;
        ALU_OP = '0;
        DATA1  = '0;
        DATA2  = '0;
        repeat (3) @(negedge CLK);
        chk("reset_result", RESULT, 32'h0);
        chk("reset_done", {31'd0, DONE}, 32'd0);
        chk("reset_busy", {31'd0, BUSY}, 32'd0);
        RESET = 1'b1;
        @(negedge CLK);

        // MUL 7 * -3 with BUSY asserted in the accept cycle
        ALU_OP = T_MUL; DATA1 = 32'd7; DATA2 = 32'hFFFF_FFFD; START = 1'b1;
        #1 chk("busy_accept", {31'd0, BUSY}, 32'd1);
        issue(T_MUL, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33, "mul_7x-3");

        // Back-to-back from FIN: one extra cycle for the IDLE accept
        issue(T_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 34, "mulh");
        issue(T_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34, "mulhsu");
        issue(T_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34, "mulhu");
        issue(T_DIV,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34, "div_-7_2");
        issue(T_REM,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34, "rem_-7_2");
        issue(T_DIVU, 32'd100, 32'd7, 32'd14, 34, "divu_100_7");
        issue(T_REMU, 32'd100, 32'd7, 32'd2, 34, "remu_100_7");
        idle(1);

        // Fast paths
        issue(T_DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, "divu_by0");
        issue(T_REM,  32'd5, 32'd0, 32'd5, 2, "rem_by0");
        issue(T_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 2, "div_ovf");
        issue(T_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 2, "rem_ovf");
        issue(T_MUL,  32'd0, 32'h1234_5678, 32'h0, 2, "mul_zero");
        idle(2);

        // FLUSH mid-DIV: no result, then a fresh MUL
        ALU_OP = T_DIV; DATA1 = 32'd1000; DATA2 = 32'd7; START = 1'b1;
        repeat (10) @(negedge CLK);
        FLUSH = 1'b1;
        #1 chk("flush_busy", {31'd0, BUSY}, 32'd0);
        @(negedge CLK);
        FLUSH = 1'b0; START = 1'b0;
        #1 chk("post_flush_busy", {31'd0, BUSY}, 32'd0);
        chk("post_flush_done", {31'd0, DONE}, 32'd0);
        idle(40);
        issue(T_MUL, 32'd3, 32'd4, 32'd12, 33, "mul_after_flush");
        idle(1);

        // START together with FLUSH in IDLE is not accepted
        ALU_OP = T_MUL; DATA1 = 32'd5; DATA2 = 32'd6; START = 1'b1; FLUSH = 1'b1;
        #1 chk("start_flush_busy", {31'd0, BUSY}, 32'd0);
        @(negedge CLK);
        START = 1'b0; FLUSH = 1'b0;
        #1 chk("start_flush_busy2", {31'd0, BUSY}, 32'd0);
        idle(3);

        // Non-M ops and bubbles leave the unit idle and RESULT untouched
        ALU_OP = 5'b00000; START = 1'b1;
        #1 chk("nonm_busy_a", {31'd0, BUSY}, 32'd0);
        ALU_OP = 5'b10001;
        #1 chk("nonm_busy_b", {31'd0, BUSY}, 32'd0);
        ALU_OP = T_DIV; START = 1'b0;
        #1 chk("bubble_busy", {31'd0, BUSY}, 32'd0);
        ALU_OP = 5'b00011; START = 1'b1;
        repeat (3) @(negedge CLK);
        chk("nonm_result_hold", RESULT, 32'd12);
        chk("nonm_done", {31'd0, DONE}, 32'd0);
        idle(1);

        // RESET during RUN abandons the op
        ALU_OP = T_MUL; DATA1 = 32'd9; DATA2 = 32'd9; START = 1'b1;
        repeat (5) @(negedge CLK);
        RESET = 1'b0; START = 1'b0;
        @(negedge CLK);
        chk("midrun_reset_result", RESULT, 32'h0);
        chk("midrun_reset_done", {31'd0, DONE}, 32'd0);
        chk("midrun_reset_busy", {31'd0, BUSY}, 32'd0);
        RESET = 1'b1;
        idle(1);

        // Randomized back-to-back stream
        for (int i = 0; i < 40; i++) begin
            rop = {2'b01, 3'($urandom_range(0, 7))};
            ra  = $urandom;
            rb  = $urandom;
            sel = $urandom_range(0, 7);
            case (sel)
                0: rb = 32'h0;
                1: ra = 32'h0;
                2: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                3: begin ra = 32'($urandom_range(0, 300)) - 32'd150; rb = 32'($urandom_range(1, 20)); end
                default: ;
            endcase
            issue(rop, ra, rb, model(rop, ra, rb), 0, "random");
        end
        idle(5);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors",
                 drv_checks + mon_checks, drv_errors + mon_errors);
        $finish;
    end

endmodule
